dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port synchronous data memory between the CPU load/store path and a debug/loader port. The loader uses the debug port to preload and inspect data memory. The block sits between both requesters and the data memory. It sequences each access through a small FSM and returns read data with a valid strobe. Grants are round-robin by default, with an optional fixed CPU priority.

---
 rtl/dmem_arbiter.sv | 251 +++++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data memory between the
// CPU load/store path and the debug/loader port. Each access runs through a
// three-state FSM (IDLE -> ISSUE -> [RESP] -> IDLE). Grants are round-robin
// unless CPU_PRIO=1, in which case the CPU wins every contention.
// Optional feature macro: DMEM_ARB_LOCK_EN adds dbg_lock, which keeps the
// memory locked to the debug port for loader bursts.
module dmem_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter bit CPU_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic              dbg_lock,
`endif
    output logic              dbg_ack,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic              cpu_cand_s;
    logic              grant_vld_s, grant_dbg_s;

    // Registered outputs and internal state, with their next values.
    logic              cpu_ack_r, cpu_ack_d;
    logic              dbg_ack_r, dbg_ack_d;
    logic              cpu_rvalid_r, cpu_rvalid_d;
    logic              dbg_rvalid_r, dbg_rvalid_d;
    logic [DATA_W-1:0] cpu_rdata_r, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_r, dbg_rdata_d;
    logic              mem_we_r, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_d;
    logic              owner_r, owner_d;
    logic              busy_r, busy_d;
    logic              we_r, we_d;
    logic              last_dbg_r, last_dbg_d;

`ifdef DMEM_ARB_LOCK_EN
    logic              lock_r, lock_d;
    // While locked to debug and dbg_lock is still high, the CPU is not a candidate.
    always_comb begin
        cpu_cand_s = cpu_req & ~(lock_r & dbg_lock);
    end
`else
    // Without the lock feature the CPU is always a candidate when requesting.
    always_comb begin
        cpu_cand_s = cpu_req;
    end
`endif

    // Arbitration: pick the winner among the current requesters.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_dbg_s = 1'b0;
        if (cpu_cand_s && dbg_req) begin
            grant_vld_s = 1'b1;
            if (CPU_PRIO) begin
                grant_dbg_s = 1'b0;
            end else begin
                grant_dbg_s = ~last_dbg_r;
            end
        end else if (cpu_cand_s) begin
            grant_vld_s = 1'b1;
            grant_dbg_s = 1'b0;
        end else if (dbg_req) begin
            grant_vld_s = 1'b1;
            grant_dbg_s = 1'b1;
        end else begin
            grant_vld_s = 1'b0;
            grant_dbg_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic: writes skip RESP, reads take one RESP cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_vld_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (we_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next values for every registered output.
    always_comb begin
        cpu_ack_d    = 1'b0;
        dbg_ack_d    = 1'b0;
        cpu_rvalid_d = 1'b0;
        dbg_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_r;
        dbg_rdata_d  = dbg_rdata_r;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        owner_d      = owner_r;
        busy_d       = (state_s != ST_IDLE);
        we_d         = we_r;
        last_dbg_d   = last_dbg_r;
`ifdef DMEM_ARB_LOCK_EN
        lock_d       = lock_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (grant_vld_s) begin
                    owner_d    = grant_dbg_s;
                    last_dbg_d = grant_dbg_s;
                    cpu_ack_d  = ~grant_dbg_s;
                    dbg_ack_d  = grant_dbg_s;
                    if (grant_dbg_s) begin
                        we_d        = dbg_we;
                        mem_we_d    = dbg_we;
                        mem_addr_d  = dbg_addr;
                        mem_wdata_d = dbg_wdata;
                    end else begin
                        we_d        = cpu_we;
                        mem_we_d    = cpu_we;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                    end
`ifdef DMEM_ARB_LOCK_EN
                    lock_d = grant_dbg_s & dbg_lock;
                end else if (!dbg_lock) begin
                    lock_d = 1'b0;
`endif
                end else begin
                    owner_d = owner_r;
                end
            end
            ST_ISSUE: begin
                // A read keeps the address on the bus through RESP.
                if (!we_r) begin
                    mem_addr_d  = mem_addr_r;
                    mem_wdata_d = mem_wdata_r;
                end else begin
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                end
            end
            ST_RESP: begin
                if (owner_r) begin
                    dbg_rdata_d  = mem_rdata;
                    dbg_rvalid_d = 1'b1;
                end else begin
                    cpu_rdata_d  = mem_rdata;
                    cpu_rvalid_d = 1'b1;
                end
            end
            default: mem_we_d = 1'b0;
        endcase
    end

    // Output and datapath registers; reset drops any in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_ack_r    <= 1'b0;
            dbg_ack_r    <= 1'b0;
            cpu_rvalid_r <= 1'b0;
            dbg_rvalid_r <= 1'b0;
            cpu_rdata_r  <= '0;
            dbg_rdata_r  <= '0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            owner_r      <= 1'b0;
            busy_r       <= 1'b0;
            we_r         <= 1'b0;
            last_dbg_r   <= 1'b1;
`ifdef DMEM_ARB_LOCK_EN
            lock_r       <= 1'b0;
`endif
        end else begin
            cpu_ack_r    <= cpu_ack_d;
            dbg_ack_r    <= dbg_ack_d;
            cpu_rvalid_r <= cpu_rvalid_d;
            dbg_rvalid_r <= dbg_rvalid_d;
            cpu_rdata_r  <= cpu_rdata_d;
            dbg_rdata_r  <= dbg_rdata_d;
            mem_we_r     <= mem_we_d;
            mem_addr_r   <= mem_addr_d;
            mem_wdata_r  <= mem_wdata_d;
            owner_r      <= owner_d;
            busy_r       <= busy_d;
            we_r         <= we_d;
            last_dbg_r   <= last_dbg_d;
`ifdef DMEM_ARB_LOCK_EN
            lock_r       <= lock_d;
`endif
        end
    end

    assign cpu_ack    = cpu_ack_r;
    assign dbg_ack    = dbg_ack_r;
    assign cpu_rvalid = cpu_rvalid_r;
    assign dbg_rvalid = dbg_rvalid_r;
    assign cpu_rdata  = cpu_rdata_r;
    assign dbg_rdata  = dbg_rdata_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign owner      = owner_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: a round-robin instance (u_rr) driven by a
// cycle-by-cycle vector table plus hand-written reset and lock sequences,
// and a CPU-priority instance (u_pr) sharing the same stimulus.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int DW = 32;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata;

    logic          a_cpu_ack, a_cpu_rvalid, a_dbg_ack, a_dbg_rvalid, a_mem_we, a_owner, a_busy;
    logic [DW-1:0] a_cpu_rdata, a_dbg_rdata, a_mem_wdata, a_mem_rdata;
    logic [AW-1:0] a_mem_addr;
    logic          p_cpu_ack, p_cpu_rvalid, p_dbg_ack, p_dbg_rvalid, p_mem_we, p_owner, p_busy;
    logic [DW-1:0] p_cpu_rdata, p_dbg_rdata, p_mem_wdata, p_mem_rdata;
    logic [AW-1:0] p_mem_addr;

    logic [DW-1:0] mem_a [64];
    logic [DW-1:0] mem_p [64];

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CPU_PRIO(1'b0)) u_rr (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(a_cpu_ack), .cpu_rvalid(a_cpu_rvalid), .cpu_rdata(a_cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
`ifdef DMEM_ARB_LOCK_EN
        .dbg_lock(dbg_lock),
`endif
        .dbg_ack(a_dbg_ack), .dbg_rvalid(a_dbg_rvalid), .dbg_rdata(a_dbg_rdata),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .owner(a_owner), .busy(a_busy)
    );

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CPU_PRIO(1'b1)) u_pr (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(p_cpu_ack), .cpu_rvalid(p_cpu_rvalid), .cpu_rdata(p_cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
`ifdef DMEM_ARB_LOCK_EN
        .dbg_lock(dbg_lock),
`endif
        .dbg_ack(p_dbg_ack), .dbg_rvalid(p_dbg_rvalid), .dbg_rdata(p_dbg_rdata),
        .mem_we(p_mem_we), .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata), .mem_rdata(p_mem_rdata),
        .owner(p_owner), .busy(p_busy)
    );

    // Single-port synchronous memories: read data valid the cycle after the address.
    always @(posedge clk) begin
        if (a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
        a_mem_rdata <= mem_a[a_mem_addr];
        if (p_mem_we) mem_p[p_mem_addr] <= p_mem_wdata;
        p_mem_rdata <= mem_p[p_mem_addr];
    end

    logic [108:0] a_all, p_all;
    assign a_all = {a_cpu_ack, a_cpu_rvalid, a_dbg_ack, a_dbg_rvalid, a_mem_we, a_mem_addr,
                    a_mem_wdata, a_owner, a_busy, a_cpu_rdata, a_dbg_rdata};
    assign p_all = {p_cpu_ack, p_cpu_rvalid, p_dbg_ack, p_dbg_rvalid, p_mem_we, p_mem_addr,
                    p_mem_wdata, p_owner, p_busy, p_cpu_rdata, p_dbg_rdata};

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          cr, cw;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic          dr, dw;
        logic [AW-1:0] da;
        logic [DW-1:0] dd;
        logic [4:0]    e_flags;   // {cpu_ack, cpu_rvalid, dbg_ack, dbg_rvalid, mem_we}
        logic [AW-1:0] e_maddr;
        logic          e_own, e_busy;
        logic [DW-1:0] e_crd, e_drd;
    } vec_t;

    function automatic vec_t mk(logic cr, logic cw, logic [AW-1:0] ca, logic [DW-1:0] cd,
                                logic dr, logic dw, logic [AW-1:0] da, logic [DW-1:0] dd,
                                logic [4:0] fl, logic [AW-1:0] ma, logic own, logic bsy,
                                logic [DW-1:0] crd, logic [DW-1:0] drd);
        vec_t v;
        v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.e_flags = fl; v.e_maddr = ma; v.e_own = own; v.e_busy = bsy;
        v.e_crd = crd; v.e_drd = drd;
        return v;
    endfunction

    vec_t tbl [20];
    localparam logic [DW-1:0] D = 32'hDEADBEEF;
    localparam logic [DW-1:0] E = 32'h12345678;

    initial begin
        int p_cack_n;
        int p_dack_n;
        int w;
        logic [AW-1:0] k6;
        p_cack_n = 0;
        p_dack_n = 0;

        //         cr  cw  ca     cd     dr  dw  da     dd     flags     maddr own bsy crd  drd
        tbl[0]  = mk(0, 0, 6'd0, 32'h0, 0, 0, 6'd0, 32'h0, 5'b00000, 6'd0, 0, 0, 32'h0, 32'h0);
        tbl[1]  = mk(1, 1, 6'd5, D,     0, 0, 6'd0, 32'h0, 5'b10001, 6'd5, 0, 1, 32'h0, 32'h0);
        tbl[2]  = mk(0, 0, 6'd0, 32'h0, 0, 0, 6'd0, 32'h0, 5'b00000, 6'd0, 0, 0, 32'h0, 32'h0);
        tbl[3]  = mk(1, 0, 6'd5, 32'h0, 0, 0, 6'd0, 32'h0, 5'b10000, 6'd5, 0, 1, 32'h0, 32'h0);
        tbl[4]  = mk(0, 0, 6'd0, 32'h0, 0, 0, 6'd0, 32'h0, 5'b00000, 6'd5, 0, 1, 32'h0, 32'h0);
        tbl[5]  = mk(0, 0, 6'd0, 32'h0, 0, 0, 6'd0, 32'h0, 5'b01000, 6'd0, 0, 0, D,     32'h0);
        tbl[6]  = mk(0, 0, 6'd0, 32'h0, 1, 1, 6'd7, E,     5'b00101, 6'd7, 1, 1, D,     32'h0);
        tbl[7]  = mk(0, 0, 6'd0, 32'h0, 0, 0, 6'd0, 32'h0, 5'b00000, 6'd0, 1, 0, D,     32'h0);
        tbl[8]  = mk(1, 0, 6'd7, 32'h0, 1, 0, 6'd5, 32'h0, 5'b10000, 6'd7, 0, 1, D,     32'h0);
        tbl[9]  = mk(1, 0, 6'd7, 32'h0, 1, 0, 6'd5, 32'h0, 5'b00000, 6'd7, 0, 1, D,     32'h0);
        tbl[10] = mk(1, 0, 6'd7, 32'h0, 1, 0, 6'd5, 32'h0, 5'b01000, 6'd0, 0, 0, E,     32'h0);
        tbl[11] = mk(1, 0, 6'd7, 32'h0, 1, 0, 6'd5, 32'h0, 5'b00100, 6'd5, 1, 1, E,     32'h0);
        tbl[12] = mk(1, 0, 6'd7, 32'h0, 1, 0, 6'd5, 32'h0, 5'b00000, 6'd5, 1, 1, E,     32'h0);
        tbl[13] = mk(1, 0, 6'd7, 32'h0, 1, 0, 6'd5, 32'h0, 5'b00010, 6'd0, 1, 0, E,     D);
        tbl[14] = mk(1, 0, 6'd7, 32'h0, 1, 0, 6'd5, 32'h0, 5'b10000, 6'd7, 0, 1, E,     D);
        tbl[15] = mk(1, 0, 6'd7, 32'h0, 1, 0, 6'd5, 32'h0, 5'b00000, 6'd7, 0, 1, E,     D);
        tbl[16] = mk(1, 0, 6'd7, 32'h0, 1, 0, 6'd5, 32'h0, 5'b01000, 6'd0, 0, 0, E,     D);
        tbl[17] = mk(1, 0, 6'd7, 32'h0, 1, 0, 6'd5, 32'h0, 5'b00100, 6'd5, 1, 1, E,     D);
        tbl[18] = mk(0, 0, 6'd0, 32'h0, 0, 0, 6'd0, 32'h0, 5'b00000, 6'd5, 1, 1, E,     D);
        tbl[19] = mk(0, 0, 6'd0, 32'h0, 0, 0, 6'd0, 32'h0, 5'b00010, 6'd0, 1, 0, E,     D);

        // Reset with both ports requesting: everything stays at zero.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rr", 128'(a_all), 128'(0));
        chk("reset_pr", 128'(p_all), 128'(0));
        rst = 1'b1;
        step();
        chk("first_grant_cpu", 128'({a_cpu_ack, a_dbg_ack, a_owner, a_busy}), 128'(4'b1001));
        cpu_req = 1'b0; dbg_req = 1'b0;
        step();

        // Cycle-by-cycle table.
        for (int i = 0; i < 20; i++) begin
            cpu_req = tbl[i].cr; cpu_we = tbl[i].cw; cpu_addr = tbl[i].ca; cpu_wdata = tbl[i].cd;
            dbg_req = tbl[i].dr; dbg_we = tbl[i].dw; dbg_addr = tbl[i].da; dbg_wdata = tbl[i].dd;
            step();
            chk($sformatf("row%0d", i),
                128'({a_cpu_ack, a_cpu_rvalid, a_dbg_ack, a_dbg_rvalid, a_mem_we, a_mem_addr,
                      a_owner, a_busy, a_cpu_rdata, a_dbg_rdata}),
                128'({tbl[i].e_flags, tbl[i].e_maddr, tbl[i].e_own, tbl[i].e_busy,
                      tbl[i].e_crd, tbl[i].e_drd}));
            if (i >= 8) begin
                p_cack_n += int'(p_cpu_ack);
                p_dack_n += int'(p_dbg_ack);
            end
        end
        chk("prio_grants", 128'({p_cack_n[3:0], p_dack_n[3:0]}), 128'({4'd4, 4'd0}));

        // Reset during RESP of a debug read: no rvalid, immediate clear.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd7;
        step();
        chk("dbg_rd_issue", 128'({a_dbg_ack, a_owner, a_busy}), 128'(3'b111));
        dbg_req = 1'b0;
        step();
        chk("dbg_rd_resp", 128'({a_busy, a_owner, a_mem_addr}), 128'({1'b1, 1'b1, 6'd7}));
        #2 rst = 1'b0;
        #1;
        chk("rst_async_clear", 128'(a_all), 128'(0));
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("in_reset%0d", i), 128'(a_all), 128'(0));
        end
        rst = 1'b1;
        step();
        chk("after_reset_idle", 128'(a_all), 128'(0));
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd5;
        step();
        chk("restart_ack", 128'({a_cpu_ack, a_mem_addr}), 128'({1'b1, 6'd5}));
        cpu_req = 1'b0;
        step();
        step();
        chk("restart_rdata", 128'({a_cpu_rvalid, a_cpu_rdata}), 128'({1'b1, D}));

`ifdef DMEM_ARB_LOCK_EN
        // Loader burst: debug locked for four back-to-back writes while the CPU waits.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'd20; cpu_wdata = 32'hCAFE0000;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_lock = 1'b1;
        for (int k = 0; k < 4; k++) begin
            k6 = 6'(k);
            dbg_addr = k6; dbg_wdata = 32'hA0 + 32'(k);
            w = 0;
            do begin
                step();
                w++;
            end while (!a_dbg_ack && !a_cpu_ack && w < 4);
            chk($sformatf("lock_wr%0d", k),
                128'({a_dbg_ack, a_cpu_ack, a_mem_addr, w[2:0]}),
                128'({1'b1, 1'b0, k6, (k == 0) ? 3'd1 : 3'd2}));
        end
        dbg_lock = 1'b0; dbg_req = 1'b0;
        w = 0;
        do begin
            step();
            w++;
        end while (!a_cpu_ack && w < 4);
        chk("cpu_after_unlock", 128'({a_cpu_ack, a_mem_addr, w[2:0]}), 128'({1'b1, 6'd20, 3'd2}));
        cpu_req = 1'b0;
        step();
        chk("burst_mem", 128'({mem_a[0], mem_a[1], mem_a[2], mem_a[3]}),
            128'({32'hA0, 32'hA1, 32'hA2, 32'hA3}));
        chk("cpu_wr_mem", 128'(mem_a[20]), 128'(32'hCAFE0000));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
